// File: rtl/word_serializer.sv
// word_serializer: parallel word to valid/ready bit stream
//   clk_i          clock, all state changes on posedge
//   rst_ni         synchronous reset, active-low
//   enable_i       1 = run, 0 = freeze all state (no handshake completes)
//   load_valid_i   load_data_i is valid
//   load_ready_o   block can accept a word (enabled and idle)
//   load_data_i    parallel word
//   bit_valid_o    bit_out_o is valid (enabled and shifting)
//   bit_ready_i    downstream takes bit_out_o
//   bit_out_o      current serial bit
//   bit_last_o     current bit is the final bit of the word
//   busy_o         word in flight
module word_serializer #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic             bit_out_o,
    output logic             bit_last_o,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic load_fire, bit_fire, last;
    // Handshakes are gated by enable through the ready/valid outputs, so a
    // disabled block holds every register without extra qualification.
    assign load_fire = load_valid_i & load_ready_o;
    assign bit_fire  = bit_valid_o & bit_ready_i;
    assign last      = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = load_fire ? SHIFT : (bit_fire && last) ? IDLE : state_q;
        sreg_d  = load_fire ? load_data_i
                : !bit_fire ? sreg_q
                : LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = load_fire ? '0
                : !bit_fire ? cnt_q
                : last ? '0 : cnt_q + 1'b1;
    end
    always_comb begin
        load_ready_o = enable_i && (state_q == IDLE);
        bit_valid_o  = enable_i && (state_q == SHIFT);
        busy_o       = (state_q == SHIFT);
        bit_out_o    = (state_q == SHIFT) ? (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]) : 1'b0;
        bit_last_o   = last;
    end
endmodule
